fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and the FIFO entry payload for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = ~(XLEN'(INSN_BYTES) - XLEN'(1));

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with synchronous flush and async reset.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Flush dominates; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, request credit, redirect drop accounting and prefetch FIFO.
// Optional misaligned-redirect trap entry enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2,
  parameter int unsigned     CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins_data,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            ins_misalign,
`endif
  output logic [XLEN-1:0] ins_pc
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] credit_used;
  logic [XLEN-1:0]  redir_pc;
  logic             req_fire, push, pop, flush, fetch_halt;
  fetch_entry_t     push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q, halt_d, trap_pend_q, trap_pend_d, trap_out_q, trap_out_d;
  logic redir_misalign;
  assign redir_pc       = redirect_pc;
  assign redir_misalign = |redirect_pc[1:0];
  assign fetch_halt     = halt_q;
  assign ins_misalign   = trap_out_q;
`else
  assign redir_pc   = redirect_pc & PC_ALIGN_MASK;
  assign fetch_halt = 1'b0;
`endif

  // Credit counts words either buffered or still owed to the FIFO.
  assign credit_used    = SUM_W'(outstanding_q - drop_q) + SUM_W'(fifo_count);
  assign imem_req_valid = !rst && !redirect_valid && !fetch_halt &&
                          (outstanding_q < CNT_W'(DEPTH)) && (credit_used < SUM_W'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    push_entry    = '{pc: rsp_pc_q, data: imem_rsp_data};
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d      = halt_q;
    trap_pend_d = trap_pend_q;
    trap_out_d  = trap_out_q;
`endif
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response must be discarded.
      flush         = 1'b1;
      fetch_pc_d    = redir_pc;
      rsp_pc_d      = redir_pc;
      outstanding_d = outstanding_q - CNT_W'(imem_rsp_valid);
      drop_d        = outstanding_q - CNT_W'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d      = redir_misalign;
      trap_pend_d = redir_misalign;
      trap_out_d  = 1'b0;
`endif
    end else begin
      pop           = ins_valid && ins_ready;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSN_BYTES);
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + XLEN'(INSN_BYTES);
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pop) trap_out_d = 1'b0;
      // Fetch is halted, so once drops drain nothing else can arrive.
      if (trap_pend_q && drop_q == '0) begin
        push        = 1'b1;
        push_entry  = '{pc: rsp_pc_q, data: '0};
        trap_pend_d = 1'b0;
        trap_out_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q      <= 1'b0;
      trap_pend_q <= 1'b0;
      trap_out_q  <= 1'b0;
    end else begin
      halt_q      <= halt_d;
      trap_pend_q <= trap_pend_d;
      trap_out_q  <= trap_out_d;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign ins_valid = (fifo_count != '0);
  assign ins_data  = head.data;
  assign ins_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and an instruction scoreboard.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        ins_misalign;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_data       (ins_data),
`ifdef FETCH_MISALIGN_TRAP_EN
    .ins_misalign   (ins_misalign),
`endif
    .ins_pc         (ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int unsigned due_q[$];
  logic [31:0] pop_log[$];
  int unsigned cyc;
  int unsigned lat;
  bit          rdy_rand;
  logic [31:0] model_pc;
  int          n_checks;
  int          n_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (ins_valid !== 1'b1 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(ins_valid), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Memory model plus scoreboard: drive at negedge, observe handshakes just before posedge.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cyc            = 0;
    model_pc       = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (due_q.size() != 0 && due_q[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(addr_q[0]);
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        due_q.delete();
        model_pc = 32'h0;
      end else if (redirect_valid) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        model_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) exp_q.push_back('{redirect_pc, 32'h0, 1'b1});
`else
        model_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          check("imem_addr", imem_addr, model_pc);
          addr_q.push_back(imem_addr);
          due_q.push_back(cyc + lat);
          exp_q.push_back('{model_pc, mem_word(model_pc), 1'b0});
          model_pc = model_pc + 32'd4;
        end
        if (ins_valid && ins_ready) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("ins_pc", ins_pc, exp_q[0].pc);
            check("ins_data", ins_data, exp_q[0].data);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("ins_misalign", 32'(ins_misalign), 32'(exp_q[0].mis));
`endif
            void'(exp_q.pop_front());
            pop_log.push_back(ins_pc);
          end
        end
        if (dut.push) check("fifo_overflow", 32'(dut.fifo_count == 2'(DEPTH)), 32'd0);
      end
    end
  end

  initial begin
    int n;
    n_checks       = 0;
    n_err          = 0;
    lat            = 1;
    rdy_rand       = 1'b0;
    rst            = 1'b1;
    ins_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    step(2);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_data", ins_data, 32'd0);
    check("rst_ins_pc", ins_pc, 32'd0);
    check("rst_fetch_pc", imem_addr, 32'd0);

    // First accept in this cycle; instruction visible two cycles later.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'd0);
    step(1);
    check("no_bypass", 32'(ins_valid), 32'd0);
    step(1);
    check("first_ins_valid", 32'(ins_valid), 32'd1);
    check("first_ins_pc", ins_pc, 32'd0);
    step(20);

    // Full stall: the FIFO fills to DEPTH and requests stop.
    ins_ready = 1'b0;
    step(10);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_ins_valid", 32'(ins_valid), 32'd1);
    check("stall_buffered", 32'(exp_q.size()), 32'(DEPTH));
    ins_ready = 1'b1;
    step(10);

    // Random ready with three-cycle latency.
    rdy_rand = 1'b1;
    lat      = 3;
    step(60);
    rdy_rand = 1'b0;

    // Redirect with two responses in flight.
    n = 0;
    while (due_q.size() != 2 && n < 50) begin step(1); n++; end
    check("inflight_two", 32'(due_q.size()), 32'd2);
    redirect(32'h0000_0100);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_flush", 32'(ins_valid), 32'd0);
    wait_valid("redir_valid");
    check("redir_ins_pc", ins_pc, 32'h0000_0100);
    step(6);

    // Redirect that coincides with a pop and a response.
    lat = 1;
    step(4);
    n = 0;
    while (!(ins_valid === 1'b1 && imem_rsp_valid === 1'b1) && n < 50) begin step(1); n++; end
    check("coincide_found", 32'(ins_valid && imem_rsp_valid), 32'd1);
    redirect(32'h0000_0200);
    check("coincide_empty", 32'(ins_valid), 32'd0);
    wait_valid("coincide_valid");
    check("coincide_pc", ins_pc, 32'h0000_0200);
    step(6);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect produces one trap entry and halts fetch.
    ins_ready = 1'b0;
    redirect(32'h0000_0102);
    wait_valid("trap_valid");
    check("trap_flag", 32'(ins_misalign), 32'd1);
    check("trap_pc", ins_pc, 32'h0000_0102);
    check("trap_data", ins_data, 32'h0);
    check("trap_halt", 32'(imem_req_valid), 32'd0);
    ins_ready = 1'b1;
    step(1);
    check("trap_single", 32'(ins_valid), 32'd0);
    step(4);
    check("trap_still_halt", 32'(imem_req_valid), 32'd0);
    redirect(32'h0000_0200);
    check("trap_resume_valid", 32'(imem_req_valid), 32'd1);
    check("trap_resume_addr", imem_addr, 32'h0000_0200);
    step(6);
`else
    // Low address bits of a redirect target are ignored.
    redirect(32'h0000_0302);
    check("align_addr", imem_addr, 32'h0000_0300);
    wait_valid("align_valid");
    check("align_pc", ins_pc, 32'h0000_0300);
    step(6);
`endif

    // 32-bit PC wrap.
    step(3);
    redirect(32'hFFFF_FFF8);
    pop_log.delete();
    n = 0;
    while (pop_log.size() < 3 && n < 60) begin step(1); n++; end
    check("wrap_count", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
      check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
      check("wrap_pc2", pop_log[2], 32'h0000_0000);
    end
    step(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
